mem_bist_ctrl: RTL

MEM_BIST_CTRL -- requirements
Module: mem_bist_ctrl

---
 rtl/mem_bist_pkg.sv | 23 ++
 rtl/mem_bist_cmp.sv | 67 ++++++
 rtl/mem_bist_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/mem_bist_pkg.sv
// Shared types and helpers for the memory BIST controller: FSM states,
// the expected-data pattern and the error counter width.
package mem_bist_pkg;

  localparam int unsigned ErrCntW = 8;

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StRead,
    StDrain,
    StFinish
  } bist_state_e;

  // Expected word for address a. Callers truncate the result to their own data width (<= 64).
  function automatic logic [63:0] bist_data(input logic [63:0] seed, input logic [63:0] addr,
                                            input logic inv);
    logic [63:0] d;
    d = seed ^ addr;
    return inv ? ~d : d;
  endfunction

endpackage

// File: rtl/mem_bist_cmp.sv
// Read-data checker: compares each read one cycle after issue, captures the
// first failing address/data and keeps a saturating mismatch count.
module mem_bist_cmp
  import mem_bist_pkg::*;
#(
  parameter int unsigned      WIDTH   = 8,
  parameter int unsigned      ADDR_W  = 3,
  parameter logic [WIDTH-1:0] PATTERN = '0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clear_i,
  input  logic               rd_issue_i,
  input  logic [ADDR_W-1:0]  rd_addr_i,
  input  logic               rd_inv_i,
  input  logic [WIDTH-1:0]   rdata_i,
  output logic [ADDR_W-1:0]  fail_addr_o,
  output logic [WIDTH-1:0]   fail_data_o,
  output logic [ErrCntW-1:0] err_cnt_o,
  output logic               clean_o
);

  logic               chk_q;
  logic [ADDR_W-1:0]  chk_addr_q;
  logic               chk_inv_q;
  logic [ADDR_W-1:0]  fail_addr_q;
  logic [WIDTH-1:0]   fail_data_q;
  logic [ErrCntW-1:0] err_cnt_q;
  logic [WIDTH-1:0]   exp_data;
  logic               mismatch;

  // clean_o folds in the compare happening this cycle so the final verdict sees the last read.
  always_comb begin
    exp_data = WIDTH'(bist_data(64'(PATTERN), 64'(chk_addr_q), chk_inv_q));
    mismatch = chk_q && (rdata_i != exp_data);
    clean_o  = (err_cnt_q == '0) && !mismatch;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      chk_q       <= 1'b0;
      chk_addr_q  <= '0;
      chk_inv_q   <= 1'b0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      chk_q      <= rd_issue_i;
      chk_addr_q <= rd_addr_i;
      chk_inv_q  <= rd_inv_i;
      if (mismatch) begin
        if (err_cnt_q == '0) begin
          fail_addr_q <= chk_addr_q;
          fail_data_q <= rdata_i;
        end
        if (err_cnt_q != '1) begin
          err_cnt_q <= err_cnt_q + ErrCntW'(1);
        end
      end
    end
  end

  assign fail_addr_o = fail_addr_q;
  assign fail_data_o = fail_data_q;
  assign err_cnt_o   = err_cnt_q;

endmodule

// File: rtl/mem_bist_ctrl.sv
// March-style write/read BIST controller for a registered-read memory.
// Define MEM_BIST_INV_PASS_EN to add a second pass with inverted data.
module mem_bist_ctrl
  import mem_bist_pkg::*;
#(
  parameter int unsigned      WIDTH   = 8,
  parameter int unsigned      DEPTH   = 8,
  parameter logic [WIDTH-1:0] PATTERN = WIDTH'(8'hA5),
  localparam int unsigned     ADDR_W  = $clog2(DEPTH)
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               START,
  output logic               BUSY,
  output logic               DONE,
  output logic               PASS,
  output logic [ADDR_W-1:0]  FAIL_ADDR,
  output logic [WIDTH-1:0]   FAIL_DATA,
  output logic [ErrCntW-1:0] ERR_CNT,
  output logic               CS,
  output logic               WE,
  output logic               RE,
  output logic [ADDR_W-1:0]  WADDR,
  output logic [ADDR_W-1:0]  RADDR,
  output logic [WIDTH-1:0]   WDATA,
  input  logic [WIDTH-1:0]   RDATA
);

`ifdef MEM_BIST_INV_PASS_EN
  localparam bit InvPassEn = 1'b1;
`else
  localparam bit InvPassEn = 1'b0;
`endif

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  bist_state_e       state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_nxt;
  logic              inv_q;
  logic              cs_q, we_q, re_q;
  logic [ADDR_W-1:0] waddr_q, raddr_q;
  logic [WIDTH-1:0]  wdata_q;
  logic              busy_q, done_q, pass_q;
  logic              cmp_clean;
  logic              run_start;

  function automatic logic [WIDTH-1:0] pat_word(input logic [ADDR_W-1:0] a, input logic inv);
    return WIDTH'(bist_data(64'(PATTERN), 64'(a), inv));
  endfunction

  assign addr_nxt  = addr_q + ADDR_W'(1);
  assign run_start = (state_q == StIdle) && START;

  // Memory strobes are registered and set on entry to each cycle, so they line up with state_q.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= StIdle;
      addr_q  <= '0;
      inv_q   <= 1'b0;
      cs_q    <= 1'b0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      waddr_q <= '0;
      raddr_q <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      cs_q    <= 1'b0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      waddr_q <= '0;
      raddr_q <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      case (state_q)
        StIdle: begin
          if (START) begin
            state_q <= StWrite;
            addr_q  <= '0;
            inv_q   <= 1'b0;
            pass_q  <= 1'b0;
            busy_q  <= 1'b1;
            cs_q    <= 1'b1;
            we_q    <= 1'b1;
            wdata_q <= pat_word('0, 1'b0);
          end
        end
        StWrite: begin
          cs_q <= 1'b1;
          if (addr_q == LastAddr) begin
            state_q <= StRead;
            addr_q  <= '0;
            re_q    <= 1'b1;
          end else begin
            addr_q  <= addr_nxt;
            we_q    <= 1'b1;
            waddr_q <= addr_nxt;
            wdata_q <= pat_word(addr_nxt, inv_q);
          end
        end
        StRead: begin
          if (addr_q == LastAddr) begin
            state_q <= StDrain;
            addr_q  <= '0;
          end else begin
            addr_q  <= addr_nxt;
            cs_q    <= 1'b1;
            re_q    <= 1'b1;
            raddr_q <= addr_nxt;
          end
        end
        StDrain: begin
          if (InvPassEn && !inv_q) begin
            state_q <= StWrite;
            inv_q   <= 1'b1;
            cs_q    <= 1'b1;
            we_q    <= 1'b1;
            wdata_q <= pat_word('0, 1'b1);
          end else begin
            state_q <= StFinish;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= cmp_clean;
          end
        end
        StFinish: state_q <= StIdle;
        default:  state_q <= StIdle;
      endcase
    end
  end

  mem_bist_cmp #(
    .WIDTH  (WIDTH),
    .ADDR_W (ADDR_W),
    .PATTERN(PATTERN)
  ) u_cmp (
    .clk_i      (CLK),
    .rst_i      (RESET),
    .clear_i    (run_start),
    .rd_issue_i (re_q),
    .rd_addr_i  (raddr_q),
    .rd_inv_i   (inv_q),
    .rdata_i    (RDATA),
    .fail_addr_o(FAIL_ADDR),
    .fail_data_o(FAIL_DATA),
    .err_cnt_o  (ERR_CNT),
    .clean_o    (cmp_clean)
  );

  assign BUSY  = busy_q;
  assign DONE  = done_q;
  assign PASS  = pass_q;
  assign CS    = cs_q;
  assign WE    = we_q;
  assign RE    = re_q;
  assign WADDR = waddr_q;
  assign RADDR = raddr_q;
  assign WDATA = wdata_q;

endmodule
